// File: rtl/audio_pkg.sv
// Shared constants for the audio frame transmitter.
package audio_pkg;

  localparam int unsigned SAMPLE_WIDTH = 16;
  localparam int unsigned FRAME_SLOTS  = 32;
  localparam int unsigned SLOTS_PER_CH = 16;
  localparam int unsigned SLOT_CNT_W   = $clog2(FRAME_SLOTS);
  localparam int unsigned DIV_CNT_W    = 8;

endpackage

// File: rtl/audio_clk_div.sv
// Bit-clock divider: counts 0..BCLK_DIV-1, toggles bclk at terminal count and
// flags the 1->0 toggle with a combinational strobe for the serializer.
module audio_clk_div
  import audio_pkg::*;
#(
  parameter int unsigned BCLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic bclk,
  output logic fall_c
);

  logic [DIV_CNT_W-1:0] div_cnt;
  logic                 terminal_c;

  assign terminal_c = (div_cnt == DIV_CNT_W'(BCLK_DIV - 1));
  // Asserted in the cycle whose closing edge takes bclk from 1 to 0.
  assign fall_c     = terminal_c & bclk;

  // Divider counter and bclk toggle.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      bclk    <= 1'b1;
    end else if (terminal_c) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + DIV_CNT_W'(1);
    end
  end

endmodule

// File: rtl/audio_frame_tx.sv
// Left-justified serial audio transmitter: mono sample duplicated to both
// slots of a 32-slot frame, with frame-sync and underrun strobes.
// Optional feature macro: AUDIO_FRAME_TX_UNDERRUN_CNT_EN adds an 8-bit
// saturating underrun_count output.
module audio_frame_tx #(
  parameter int unsigned BCLK_DIV     = 4,
  parameter int unsigned SAMPLE_WIDTH = audio_pkg::SAMPLE_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    new_sample_generated,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  output logic                    new_frame,
  output logic                    bclk,
  output logic                    lrclk,
  output logic                    sdata,
  output logic                    underrun
`ifdef AUDIO_FRAME_TX_UNDERRUN_CNT_EN
  ,
  output logic [7:0]              underrun_count
`endif
);

  import audio_pkg::*;

  localparam int unsigned SHIFT_W = 2 * SAMPLE_WIDTH;

  logic                    fall_c;
  logic                    frame_start_c;
  logic [SLOT_CNT_W-1:0]   bit_cnt;
  logic [SHIFT_W-1:0]      shift;
  logic [SAMPLE_WIDTH-1:0] hold;
  logic                    pending;

  audio_clk_div #(
    .BCLK_DIV (BCLK_DIV)
  ) u_clk_div (
    .clk    (clk),
    .reset  (reset),
    .bclk   (bclk),
    .fall_c (fall_c)
  );

  // Frame boundary: the falling toggle that wraps the slot counter to zero.
  assign frame_start_c = fall_c & (bit_cnt == SLOT_CNT_W'(FRAME_SLOTS - 1));

  assign lrclk = (bit_cnt >= SLOT_CNT_W'(SLOTS_PER_CH));
  assign sdata = shift[SHIFT_W-1];

  // Slot counter and shift register advance on bclk falling toggles.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt <= SLOT_CNT_W'(FRAME_SLOTS - 1);
      shift   <= '0;
    end else if (fall_c) begin
      bit_cnt <= bit_cnt + SLOT_CNT_W'(1);
      if (frame_start_c) begin
        shift <= {hold, hold};
      end else begin
        shift <= {shift[SHIFT_W-2:0], 1'b0};
      end
    end
  end

  // Sample hold and pending flag; a coincident strobe wins over the clear so
  // the new sample is kept for the following frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold    <= '0;
      pending <= 1'b0;
    end else if (new_sample_generated) begin
      hold    <= sample_in;
      pending <= 1'b1;
    end else if (frame_start_c) begin
      pending <= 1'b0;
    end
  end

  // Registered frame-sync and underrun strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      new_frame <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      new_frame <= frame_start_c;
      underrun  <= frame_start_c & ~pending;
    end
  end

`ifdef AUDIO_FRAME_TX_UNDERRUN_CNT_EN
  // Saturating count of underrun pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      underrun_count <= '0;
    end else if (underrun && (underrun_count != 8'hFF)) begin
      underrun_count <= underrun_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_audio_frame_tx.sv
// Directed bench for audio_frame_tx at BCLK_DIV=2 (128-cycle frames).
module tb_audio_frame_tx;

  localparam int unsigned DIV   = 2;
  localparam int unsigned SW    = 16;
  localparam int          FRAME = 128;
  localparam int          RUN   = 385;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          new_sample_generated = 1'b0;
  logic [SW-1:0] sample_in = '0;
  logic          new_frame;
  logic          bclk;
  logic          lrclk;
  logic          sdata;
  logic          underrun;
`ifdef AUDIO_FRAME_TX_UNDERRUN_CNT_EN
  logic [7:0]    underrun_count;
`endif

  audio_frame_tx #(
    .BCLK_DIV     (DIV),
    .SAMPLE_WIDTH (SW)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .new_sample_generated (new_sample_generated),
    .sample_in            (sample_in),
    .new_frame            (new_frame),
    .bclk                 (bclk),
    .lrclk                (lrclk),
    .sdata                (sdata),
    .underrun             (underrun)
`ifdef AUDIO_FRAME_TX_UNDERRUN_CNT_EN
    ,
    .underrun_count       (underrun_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          scen;
    int          cyc;
    logic [15:0] sample;
  } stim_t;

  typedef struct {
    int          scen;
    int          frame_cyc;
    logic [31:0] word;
    logic        ur;
  } fexp_t;

  stim_t stim [4];
  fexp_t fexp [9];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_bclk"},      32'(bclk),      32'd1);
    chk({tag, "_lrclk"},     32'(lrclk),     32'd1);
    chk({tag, "_sdata"},     32'(sdata),     32'd0);
    chk({tag, "_new_frame"}, 32'(new_frame), 32'd0);
    chk({tag, "_underrun"},  32'(underrun),  32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    new_sample_generated = 1'b0;
    sample_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
`ifdef AUDIO_FRAME_TX_UNDERRUN_CNT_EN
    chk("reset_count", 32'(underrun_count), 32'd0);
`endif
    reset = 1'b0;
    cyc = 0;
  endtask

  // Runs one scenario from reset release to cycle RUN, checking bclk,
  // frame/underrun strobes every cycle and the serialized word per frame.
  task automatic run_scen(input int s);
    logic [31:0] word;
    logic        exp_nf;
    logic        exp_ur;
    int          off;
    int          k;
    word = '0;
    do_reset();
    while (cyc < RUN) begin
      new_sample_generated = 1'b0;
      sample_in = '0;
      foreach (stim[i]) begin
        if (stim[i].scen == s && stim[i].cyc == cyc + 1) begin
          new_sample_generated = 1'b1;
          sample_in = stim[i].sample;
        end
      end
      step();
      chk("bclk", 32'(bclk), 32'(((cyc / 2) % 2) == 0));
      exp_nf = (cyc >= 2) && (((cyc - 2) % FRAME) == 0);
      exp_ur = 1'b0;
      foreach (fexp[i]) begin
        if (fexp[i].scen == s && fexp[i].frame_cyc == cyc) exp_ur = fexp[i].ur;
      end
      chk("new_frame", 32'(new_frame), 32'(exp_nf));
      chk("underrun", 32'(underrun), 32'(exp_ur));
      if (cyc >= 2) begin
        off = (cyc - 2) % FRAME;
        k = off / 4;
        if ((off % 4) == 1) begin
          word[31-k] = sdata;
          chk("lrclk", 32'(lrclk), 32'(k >= 16));
        end
        if (off == FRAME - 1) begin
          foreach (fexp[i]) begin
            if (fexp[i].scen == s && fexp[i].frame_cyc == cyc - (FRAME - 1)) begin
              chk($sformatf("frame_word_s%0d_f%0d", s, fexp[i].frame_cyc), word, fexp[i].word);
            end
          end
        end
      end
    end
    new_sample_generated = 1'b0;
  endtask

  initial begin
    logic [31:0] word;
    int          off;

    stim[0] = '{1,  50, 16'hA5C3};
    stim[1] = '{1, 140, 16'h1111};
    stim[2] = '{1, 200, 16'h8000};
    stim[3] = '{2, 130, 16'h7FFF};

    fexp[0] = '{0,   2, 32'h0000_0000, 1'b1};
    fexp[1] = '{0, 130, 32'h0000_0000, 1'b1};
    fexp[2] = '{0, 258, 32'h0000_0000, 1'b1};
    fexp[3] = '{1,   2, 32'h0000_0000, 1'b1};
    fexp[4] = '{1, 130, 32'hA5C3_A5C3, 1'b0};
    fexp[5] = '{1, 258, 32'h8000_8000, 1'b0};
    fexp[6] = '{2,   2, 32'h0000_0000, 1'b1};
    fexp[7] = '{2, 130, 32'h0000_0000, 1'b1};
    fexp[8] = '{2, 258, 32'h7FFF_7FFF, 1'b0};

    for (int s = 0; s < 3; s++) run_scen(s);

    // Mid-frame reset with a pending sample: everything returns to reset
    // values and the pending sample is lost.
    do_reset();
    while (cyc < 189) begin
      new_sample_generated = (cyc + 1 == 20) || (cyc + 1 == 150);
      sample_in = (cyc + 1 == 20) ? 16'hFFFF : 16'h1234;
      step();
    end
    new_sample_generated = 1'b0;
    chk("pre_reset_sdata", 32'(sdata), 32'd1);
    chk("pre_reset_lrclk", 32'(lrclk), 32'd0);
    reset = 1'b1;
    step();
    chk_reset_vals("midreset");
    reset = 1'b0;
    cyc = 0;
    step();
    chk("post_reset_nf_c1", 32'(new_frame), 32'd0);
    step();
    chk("post_reset_nf_c2", 32'(new_frame), 32'd1);
    chk("post_reset_ur_c2", 32'(underrun), 32'd1);
    word = '0;
    while (cyc < 2 + FRAME - 1) begin
      off = cyc - 2;
      if ((off % 4) == 1) word[31 - off / 4] = sdata;
      step();
    end
    chk("post_reset_word", word, 32'h0000_0000);

`ifdef AUDIO_FRAME_TX_UNDERRUN_CNT_EN
    // Saturating underrun counter over 300 sample-free frames.
    do_reset();
    while (cyc < 300 * FRAME) begin
      step();
      if (cyc == 3)   chk("count_after_1", 32'(underrun_count), 32'd1);
      if (cyc == 131) chk("count_after_2", 32'(underrun_count), 32'd2);
    end
    chk("count_saturated", 32'(underrun_count), 32'd255);
    repeat (FRAME) step();
    chk("count_held", 32'(underrun_count), 32'd255);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/audio_frame_tx.md
AUDIO_FRAME_TX -- requirements
Module: audio_frame_tx

Interface
- REQ-001: Parameter BCLK_DIV, default 4: clk cycles per bclk half-period; legal range 2..255.
- REQ-002: Parameter SAMPLE_WIDTH, default 16: sample bits per channel slot.
- REQ-003: Port clk, input, 1: sole clock; all logic on its rising edge.
- REQ-004: Port reset, input, 1: synchronous, active-high reset.
- REQ-005: Port new_sample_generated, input, 1: one-cycle strobe; sample_in is valid on that cycle.
- REQ-006: Port sample_in, input, SAMPLE_WIDTH: signed PCM sample from the player.
- REQ-007: Port new_frame, output, 1: one-cycle strobe at each frame start; this is the player's frame-sync input.
- REQ-008: Port bclk, output, 1: serial bit clock.
- REQ-009: Port lrclk, output, 1: channel select; 0 = left slot, 1 = right slot.
- REQ-010: Port sdata, output, 1: serial data, MSB first.
- REQ-011: Port underrun, output, 1: one-cycle strobe when a frame starts with no fresh sample.

Function
- REQ-012: The divider counts 0..BCLK_DIV-1, toggles bclk at the terminal count, and wraps to 0.
- REQ-013: On each bclk falling toggle (1->0), bit_cnt (5 bits) increments mod 32.
- REQ-013a: On the same toggle, the shift register shifts left one place.
- REQ-014: lrclk equals bit_cnt[4], so slots 0..15 are left and slots 16..31 are right.
- REQ-015: sdata equals shift register MSB; data changes only on bclk falling edges (left-justified format, no 1-bit delay).
- REQ-016: Frame start occurs at the falling toggle where bit_cnt wraps 31->0. The frame period is 64*BCLK_DIV clk cycles.
- REQ-017: At frame start, the shift register loads {hold, hold}: the mono sample is duplicated to both channels.
- REQ-017a: new_frame pulses high for exactly one cycle at frame start.
- REQ-018: On new_sample_generated, the hold register captures sample_in and the pending flag sets. A later strobe before frame start overwrites hold (latest wins).
- REQ-019: Frame start clears pending. If pending was 0, underrun pulses for one cycle and the previous hold value is retransmitted.
- REQ-020: If new_sample_generated coincides with frame start, the frame loads the prior hold value. The new sample is captured, and pending remains set for the next frame.
- REQ-021: The coincident case of REQ-020 flags underrun only if pending was 0 before that cycle.

Reset
- REQ-022: Reset values: div_cnt=0, bclk=1, bit_cnt=31, lrclk=1, shift=0, hold=0, pending=0, sdata=0, new_frame=0, underrun=0.
- REQ-023: Reset asserted mid-frame restores REQ-022 values on the next edge and discards any pending sample.
- REQ-024: The first new_frame occurs BCLK_DIV cycles after reset deassertion. That first frame pulses underrun unless a sample arrived before it.

Configuration
- REQ-025: Macro AUDIO_FRAME_TX_UNDERRUN_CNT_EN, when defined, adds output underrun_count (8 bits).
- REQ-025a: underrun_count resets to 0, increments on each underrun pulse, and saturates at 255.
- REQ-026: Without the macro, the port and counter are absent; all other behaviour is identical.

Structure
- REQ-027: Shared package audio_pkg holds SAMPLE_WIDTH, FRAME_SLOTS=32 and SLOTS_PER_CH=16 constants.
- REQ-028: Sub-module audio_clk_div is instantiated once. It implements REQ-012 and emits bclk plus a one-cycle fall-strobe; all other logic lives in the top.

Verification (BCLK_DIV=2, frame = 128 cycles)
- REQ-029: Release reset with no samples -> new_frame at cycle 2, 130, 258. underrun pulses with each; sdata stays 0.
- REQ-030: Strobe 16'hA5C3 at cycle 50 -> frame at 130: lrclk 0 for 64 cycles, sdata bits 1010_0101_1100_0011; the same 16 bits repeat with lrclk 1; no underrun.
- REQ-031: Strobe 16'h1111 at cycle 140 and 16'h8000 at cycle 200 -> frame at 258 sends 16'h8000 in both slots; no underrun.
- REQ-032: Strobe 16'h7FFF coincident with the frame-start cycle 130, with no earlier sample -> frame 130 sends 0 and flags underrun. Frame 258 sends 16'h7FFF with no underrun.
- REQ-033: Assert reset at cycle 190, mid-frame, with a pending sample -> outputs take REQ-022 values. The next new_frame occurs 2 cycles after release, and underrun pulses with it.
- REQ-034: With the macro defined, run 300 frames with no samples -> underrun_count reads 255 and holds there.
